// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, byte FIFO with sticky
// overflow, and a serializer that drains the FIFO back-to-back onto tx.
module mmio_uart_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] DATA_ADDR    = 32'hFFFF8004,
  parameter logic [31:0] STATUS_ADDR  = 32'hFFFF8000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] read_data,
  output logic        hit,
  output logic        tx
);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [BAUD_W-1:0]  baud;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;

  logic [7:0]         fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               overflow;

  logic sel_data, sel_status, full, empty, baud_done;
  logic pop, push_req, push, drop, status_rd;
  logic [31:0] status;
  logic unused_bits;

  assign sel_data   = (address == DATA_ADDR);
  assign sel_status = (address == STATUS_ADDR);
  assign hit        = sel_data | sel_status;

  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign baud_done = (baud == BAUD_LAST);

  // A pop happens only when a new frame is entered, from IDLE or from the
  // last stop-bit cycle, so consecutive frames have no idle gap.
  assign pop       = !empty && ((state == IDLE) || ((state == STOP) && baud_done));
  assign push_req  = mem_write && sel_data;
  assign push      = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign status_rd = mem_read && sel_status;

  assign status    = {24'b0, 4'(count), overflow, (state != IDLE), empty, full};
  assign read_data = status_rd ? status : 32'b0;

  assign unused_bits = ^write_data[31:8];

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= write_data[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      // A drop on the same edge as a status read keeps the flag set.
      if (drop)           overflow <= 1'b1;
      else if (status_rd) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          baud <= '0;
          if (pop) begin
            shift   <= fifo[rd_ptr];
            bit_idx <= '0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud  <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud <= '0;
            if (pop) begin
              shift   <= fifo[rd_ptr];
              bit_idx <= '0;
              tx      <= 1'b0;
              state   <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          baud  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter for the Antares-R2 processor, downstream of the data-memory address path. It decodes the device data address (0xFFFF8004) and device status address (0xFFFF8000) on the memory bus. Byte writes to the data address go into a small FIFO. The FIFO is drained by an 8N1 serializer onto `tx`. Status reads return FIFO and transmitter state, which lets software poll before writing.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (50 MHz / 115200); minimum 2.
- `FIFO_DEPTH`, 4: byte FIFO depth; legal values 2, 4, 8.
- `DATA_ADDR`, 32'hFFFF8004: device data register address.
- `STATUS_ADDR`, 32'hFFFF8000: device status register address.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `address`  in  32  memory bus address.
- `write_data`  in  32  memory bus write data; only [7:0] used.
- `mem_write`  in  1  bus write strobe, sampled on the clock edge.
- `mem_read`  in  1  bus read strobe.
- `read_data`  out  32  device read data; combinational.
- `hit`  out  1  combinational; high when `address` equals DATA_ADDR or STATUS_ADDR. Memory suppresses its RAM access when high.
- `tx`  out  1  registered serial output; idle high.

## Operation
- **Status word:**
  - bit0 full
  - bit1 empty
  - bit2 tx_active (FSM not IDLE)
  - bit3 overflow (sticky)
  - bits[7:4] FIFO count
  - bits[31:8] zero
- **Reads:**
  - `read_data` equals the status word when `mem_read` is high and `address==STATUS_ADDR`; otherwise 0.
  - Reads of DATA_ADDR return 0.
- **Clearing overflow:** a status read (`mem_read` and `address==STATUS_ADDR` at an edge) clears overflow on that edge. If an overflow event occurs on the same edge, the set wins.
- **Push:** `mem_write` and `address==DATA_ADDR` at an edge pushes `write_data[7:0]`.
  - If full and no pop on the same edge: the byte is dropped and overflow is set.
  - If full and a pop occurs on the same edge: the push is accepted and the count is unchanged.
- **Ignored accesses:** writes to STATUS_ADDR and any access to other addresses are ignored.
- **FIFO:** circular buffer with read and write pointers that wrap modulo FIFO_DEPTH, plus a count register (0..FIFO_DEPTH).
- **Transmitter FSM:**
  - **IDLE:** `tx`=1. If the FIFO is non-empty, pop the head into an 8-bit shift register, go to START, bit counter=0.
  - **START:** `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - **DATA:** `tx`=shift[0], LSB first. Each bit is held for CLKS_PER_BIT cycles, then the register shifts right. After bit 7, go to STOP.
  - **STOP:** `tx`=1 for CLKS_PER_BIT cycles.
    - At the end, if the FIFO is non-empty: pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- **Baud counter:** counts 0..CLKS_PER_BIT-1 and resets on every state or bit change.
- **Reset (asynchronous, at any time, including mid-frame):**
  - state IDLE, `tx`=1, FIFO emptied (pointers and count 0), overflow=0, counters 0.
  - A frame in progress is aborted; no partial stop bit is generated.

## Timing
- Reset values: `tx`=1; status word=0x00000002; `read_data`=0 unless addressed; `hit` follows `address`.
- **Push to start bit:** a push at edge N into an empty, idle device is popped at edge N+1. `tx` falls after edge N+1.
- **Frame length:** exactly 10×CLKS_PER_BIT cycles, start to end of stop bit.
- **Back-to-back frames:** the next start bit begins the cycle after the last stop-bit cycle.
- **Status visibility:** status reflects register state before the current edge, since `read_data` is combinational from registers. A push at edge N is visible in count from edge N onward.
- **Pop on entering a frame:** the pop occurs on the IDLE→START and STOP→START edges. Count decrements there.

## Test plan
- **Reset:** assert `reset` mid-simulation.
  - `tx`=1 and status read = 0x00000002.
  - `hit`=1 for address 0xFFFF8000; `hit`=0 for 0xFFFF8008.
- **Single byte (CLKS_PER_BIT=4):** write 0x55 to 0xFFFF8004.
  - `tx` = 0, then 1,0,1,0,1,0,1,0, then 1, each level held 4 cycles (40 cycles total).
  - Status bit2=1 during the frame; status 0x02 after.
- **Overflow (FIFO_DEPTH=4):** write 0x10..0x15 on six consecutive cycles.
  - 0x10 is popped at once; 0x11–0x14 are queued; 0x15 is dropped.
  - Status = 0x0000004D.
  - The next status read returns 0x45.
  - Five frames 0x10–0x14 are sent back-to-back with no idle cycles.
- **Reset mid-frame:** assert `reset` during DATA bit 3 with 2 bytes queued.
  - `tx`=1 immediately; status 0x02; no further frames.
- **Simultaneous push/pop:** with the FIFO full, write 0xA5 on the edge where STOP→START pops.
  - Push accepted; count stays 4; overflow stays 0; 0xA5 is transmitted last.
- **Decode:**
  - Write to 0xFFFF8008 or 0xFFFF8000: no push; count unchanged.
  - Read of 0xFFFF8004 returns 0.
